ballot_request_queue: RTL and testbench

Upstream stage of the avatar election core. Buffers voter requests (register / vote) arriving from kiosks with a valid/ready handshake and presents them one at a time to the core. Tracks the election phase with its own cycle timer (registration, then voting, then closed), aligned to the core's phase windows. Flushes and closes the queue when the election ends.

---
 rtl/ballot_pkg.sv | 39 +++
 rtl/ballot_request_queue_if.sv | 37 +++
 rtl/ballot_request_queue_sync_fifo.sv | 63 ++++++
 rtl/ballot_request_queue.sv | 132 +++++++++++++
 tb/tb_ballot_request_queue.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ballot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ballot_pkg
// Description : Shared encodings for the ballot request queue: election
//               phase codes, request mode codes, candidate codes and the
//               packed request record.
// Revision    : 1.0 - initial release
// ============================================================================
package ballot_pkg;

  // Election phase as presented on the queue's phase output
  typedef enum logic [1:0] {
    PH_REG    = 2'd0,
    PH_VOTE   = 2'd1,
    PH_CLOSED = 2'd2
  } phase_e;

  // Request modes; codes 2 and 3 are illegal and never reach the core
  localparam logic [1:0] MODE_REG  = 2'd0;
  localparam logic [1:0] MODE_VOTE = 2'd1;

  // Candidate codes
  localparam logic [1:0] CAND_AIR   = 2'b00;
  localparam logic [1:0] CAND_FIRE  = 2'b01;
  localparam logic [1:0] CAND_EARTH = 2'b10;
  localparam logic [1:0] CAND_WATER = 2'b11;

  // Default voter ID width of the election core
  localparam int REQ_ID_W = 6;

  // One kiosk request at the core's default ID width
  typedef struct packed {
    logic [1:0]          mode;
    logic [REQ_ID_W-1:0] user_id;
    logic [1:0]          candidate;
  } req_t;

endpackage
`default_nettype wire

// File: rtl/ballot_request_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : ballot_request_queue_if
// Description : Kiosk-side and core-side valid/ready handshakes of the
//               ballot request queue.
//               master : kiosk request source and core consumer (bench/env)
//               slave  : the queue itself
//               in_*   : kiosk request (valid/ready, mode, user id, candidate)
//               out_*  : head entry toward the core (valid/ready, fields)
// Revision    : 1.0 - initial release
// ============================================================================
interface ballot_request_queue_if #(
  parameter int ID_W = 6
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_mode;
  logic [ID_W-1:0] in_user_id;
  logic [1:0]      in_candidate;

  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_mode;
  logic [ID_W-1:0] out_user_id;
  logic [1:0]      out_candidate;

  modport master (
    output in_valid, in_mode, in_user_id, in_candidate, out_ready,
    input  in_ready, out_valid, out_mode, out_user_id, out_candidate
  );

  modport slave (
    input  in_valid, in_mode, in_user_id, in_candidate, out_ready,
    output in_ready, out_valid, out_mode, out_user_id, out_candidate
  );
endinterface
`default_nettype wire

// File: rtl/ballot_request_queue_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO storage with read/write pointers, an
//               occupancy counter and a synchronous flush.
//   CLK     in   clock, rising edge
//   RST_N   in   synchronous active-low reset
//   flush   in   clear pointers and count (stored data becomes unreachable)
//   wr_en   in   write wr_data at the tail (caller guarantees not full)
//   wr_data in   WIDTH-bit entry
//   rd_en   in   advance the head (caller guarantees not empty)
//   rd_data out  current head entry, read combinationally from storage
//   count   out  occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  wire logic                     CLK,
  input  wire logic                     RST_N,
  input  wire logic                     flush,
  input  wire logic                     wr_en,
  input  wire logic [WIDTH-1:0]         wr_data,
  input  wire logic                     rd_en,
  output logic      [WIDTH-1:0]         rd_data,
  output logic      [$clog2(DEPTH):0]   count
);

  localparam int c_ptr_w = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;

  // Pointers wrap modulo DEPTH naturally because DEPTH is a power of two
  always_ff @(posedge CLK) begin
    if (!RST_N || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; the consumer gates the head while empty
  always_ff @(posedge CLK) begin
    if (wr_en && RST_N && !flush) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/ballot_request_queue.sv
`default_nettype none
// ============================================================================
// Module      : ballot_request_queue
// Description : Buffers kiosk register/vote requests and presents them one
//               at a time to the election core. Runs its own phase timer
//               (REG for PHASE_LEN cycles, then VOTE, then CLOSED) and
//               flushes/closes the queue once the election ends.
//   CLK        in   clock, rising edge
//   RST_N      in   synchronous active-low reset
//   bus        --   slave modport: in_* kiosk handshake, out_* core handshake
//   phase      out  0 = REG, 1 = VOTE, 2 = CLOSED
//   count      out  queue occupancy
//   drop_pulse out  one-cycle pulse per accepted-but-discarded request
// Optional build macro:
//   PHASE_FILTER_EN - discard requests whose mode does not match the
//                     current phase (vote during REG, register during VOTE)
// Revision    : 1.0 - initial release
// ============================================================================
module ballot_request_queue
  import ballot_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PHASE_LEN = 100,
  parameter int ID_W      = 6
) (
  input  wire logic                   CLK,
  input  wire logic                   RST_N,
  ballot_request_queue_if.slave       bus,
  output logic [1:0]                  phase,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        drop_pulse
);

  localparam int c_cnt_w = $clog2(DEPTH) + 1;
  localparam int c_end   = 2 * PHASE_LEN;
  localparam int c_tmr_w = $clog2(c_end + 1);
  localparam int c_req_w = ID_W + 4;

  localparam logic [c_tmr_w-1:0] c_tmr_vote = c_tmr_w'(PHASE_LEN);
  localparam logic [c_tmr_w-1:0] c_tmr_end  = c_tmr_w'(c_end);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(c_end - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

  logic [c_tmr_w-1:0] r_timer;
  logic               r_drop;
  phase_e             w_phase;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_push;
  logic               w_pop;
  logic               w_mode_legal;
  logic               w_phase_ok;
  logic               w_store;
  logic               w_flush;
  logic [c_req_w-1:0] w_wr_data;
  logic [c_req_w-1:0] w_head;

  // Phase timer: counts from reset and parks at the end of voting
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_timer <= '0;
    end else if (r_timer != c_tmr_end) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  always_comb begin
    w_phase = PH_CLOSED;
    if (r_timer < c_tmr_vote) begin
      w_phase = PH_REG;
    end else if (r_timer < c_tmr_end) begin
      w_phase = PH_VOTE;
    end
  end

  assign phase = w_phase;

  // Flush on the edge where the timer lands on the end value, so the queue
  // is already empty in the first CLOSED cycle
  assign w_flush = (r_timer == c_tmr_last);

  // No pass-through when full: readiness depends only on registered state
  assign w_in_ready  = (count != c_cnt_full) && (w_phase != PH_CLOSED);
  assign w_out_valid = (count != '0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  assign w_mode_legal = (bus.in_mode == MODE_REG) || (bus.in_mode == MODE_VOTE);

`ifdef PHASE_FILTER_EN
  assign w_phase_ok = !(((bus.in_mode == MODE_VOTE) && (w_phase == PH_REG)) ||
                        ((bus.in_mode == MODE_REG)  && (w_phase == PH_VOTE)));
`else
  assign w_phase_ok = 1'b1;
`endif

  assign w_store   = w_push && w_mode_legal && w_phase_ok;
  assign w_wr_data = {bus.in_mode, bus.in_user_id, bus.in_candidate};

  // Accepted but not stored requests raise drop_pulse on the next cycle
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_push && !(w_mode_legal && w_phase_ok);
    end
  end

  assign drop_pulse = r_drop;

  sync_fifo #(
    .WIDTH (c_req_w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .flush   (w_flush),
    .wr_en   (w_store),
    .wr_data (w_wr_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .count   (count)
  );

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.out_mode      = w_out_valid ? w_head[c_req_w-1 -: 2] : 2'b00;
  assign bus.out_user_id   = w_out_valid ? w_head[ID_W+1:2]       : '0;
  assign bus.out_candidate = w_out_valid ? w_head[1:0]            : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_ballot_request_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ballot_request_queue
// Description : Self-checking bench for ballot_request_queue: directed
//               scenarios plus randomized traffic compared against a
//               queue-based behavioural model of the election queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ballot_request_queue;
  import ballot_pkg::*;

  localparam int DEPTH     = 8;
  localparam int PHASE_LEN = 100;
  localparam int ID_W      = 6;
  localparam int END_T     = 2 * PHASE_LEN;

  logic       CLK;
  logic       RST_N;
  logic [1:0] phase;
  logic [3:0] count;
  logic       drop_pulse;

  ballot_request_queue_if #(.ID_W(ID_W)) bus ();

  ballot_request_queue #(
    .DEPTH     (DEPTH),
    .PHASE_LEN (PHASE_LEN),
    .ID_W      (ID_W)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .bus        (bus),
    .phase      (phase),
    .count      (count),
    .drop_pulse (drop_pulse)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a list of stored requests, a cycle counter, and the
  // pending drop indication
  req_t m_q[$];
  int   m_timer;
  bit   m_drop;

  function automatic int exp_phase(input int t);
    if (t < PHASE_LEN) return 0;
    if (t < END_T)     return 1;
    return 2;
  endfunction

  task automatic model_step(input bit v, input logic [1:0] md, input logic [5:0] id,
                            input logic [1:0] cd, input bit ordy);
    int   ph;
    bit   rdy, push, pop, keep;
    req_t r;
    ph   = exp_phase(m_timer);
    rdy  = (m_q.size() < DEPTH) && (ph != 2);
    push = v && rdy;
    pop  = (m_q.size() != 0) && ordy;
    keep = (md == 2'd0) || (md == 2'd1);
`ifdef PHASE_FILTER_EN
    if ((md == 2'd1 && ph == 0) || (md == 2'd0 && ph == 1)) keep = 1'b0;
`endif
    r.mode = md; r.user_id = id; r.candidate = cd;
    if (pop) void'(m_q.pop_front());
    if (push && keep) m_q.push_back(r);
    m_drop = push && !keep;
    if (m_timer < END_T) m_timer++;
    if (m_timer == END_T) m_q.delete();
  endtask

  // Drive one cycle of inputs, advance the model, land on the next negedge
  task automatic cycle(input bit v, input logic [1:0] md, input logic [5:0] id,
                       input logic [1:0] cd, input bit ordy);
    bus.in_valid = v; bus.in_mode = md; bus.in_user_id = id;
    bus.in_candidate = cd; bus.out_ready = ordy;
    model_step(v, md, id, cd, ordy);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 6'd0, 2'd0, 1'b0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.in_mode = 2'd0; bus.in_user_id = '0;
    bus.in_candidate = 2'd0; bus.out_ready = 1'b0;
    RST_N = 1'b0;
    m_q.delete(); m_timer = 0; m_drop = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    checks++; if ({bus.out_mode, bus.out_user_id, bus.out_candidate} !== 10'd0) begin errors++;
      $display("FAIL reset_out_fields: got %0h expected 0", {bus.out_mode, bus.out_user_id, bus.out_candidate}); end
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_drop: got %0b expected 0", drop_pulse); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
  endtask

  task automatic test_order();
    logic [5:0] ids [3];
    ids[0] = 6'd5; ids[1] = 6'd20; ids[2] = 6'd63;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, MODE_REG, ids[i], CAND_FIRE, 1'b0);
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL order_count: got %0d expected 3", count); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL order_valid: got %0b expected 1", bus.out_valid); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.out_user_id !== ids[i]) begin errors++;
        $display("FAIL order_head%0d: got %0d expected %0d", i, bus.out_user_id, ids[i]); end
      cycle(1'b0, 2'd0, 6'd0, 2'd0, 1'b1);
    end
    checks++; if (count !== 4'd0 || bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL order_drained: got count %0d valid %0b expected 0 0", count, bus.out_valid); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, MODE_REG, 6'(i + 1), CAND_EARTH, 1'b0);
    checks++; if (bus.in_ready !== 1'b0 || count !== 4'd8) begin errors++;
      $display("FAIL full_state: got ready %0b count %0d expected 0 8", bus.in_ready, count); end
    cycle(1'b1, MODE_REG, 6'd40, CAND_EARTH, 1'b1);
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_push_pop_count: got %0d expected 7", count); end
    for (int i = 2; i <= DEPTH; i++) begin
      checks++; if (bus.out_user_id !== 6'(i)) begin errors++;
        $display("FAIL full_drain_id: got %0d expected %0d", bus.out_user_id, i); end
      cycle(1'b0, 2'd0, 6'd0, 2'd0, 1'b1);
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL full_drain_count: got %0d expected 0", count); end
  endtask

  task automatic test_illegal();
    do_reset();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %0b expected 1", bus.in_ready); end
    cycle(1'b1, 2'd3, 6'd9, CAND_WATER, 1'b0);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL illegal_count: got %0d expected 0", count); end
    checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL illegal_drop: got %0b expected 1", drop_pulse); end
    idle(1);
    checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL illegal_drop_width: got %0b expected 0", drop_pulse); end
  endtask

  task automatic test_phase_filter();
    do_reset();
    idle(10);
    cycle(1'b1, MODE_VOTE, 6'd11, CAND_AIR, 1'b0);
`ifdef PHASE_FILTER_EN
    checks++; if (drop_pulse !== 1'b1 || count !== 4'd0) begin errors++;
      $display("FAIL filter_reg_vote: got drop %0b count %0d expected 1 0", drop_pulse, count); end
`else
    checks++; if (drop_pulse !== 1'b0 || count !== 4'd1) begin errors++;
      $display("FAIL nofilter_reg_vote: got drop %0b count %0d expected 0 1", drop_pulse, count); end
    cycle(1'b0, 2'd0, 6'd0, 2'd0, 1'b1);
`endif
    idle(150 - m_timer);
    cycle(1'b1, MODE_VOTE, 6'd12, CAND_AIR, 1'b0);
    checks++; if (drop_pulse !== 1'b0 || count !== 4'd1) begin errors++;
      $display("FAIL phase_vote_store: got drop %0b count %0d expected 0 1", drop_pulse, count); end
  endtask

  task automatic test_close();
    do_reset();
    idle(190);
    for (int i = 0; i < 4; i++) cycle(1'b1, MODE_VOTE, 6'(30 + i), CAND_FIRE, 1'b0);
    idle(END_T - 1 - m_timer);
    checks++; if (count !== 4'd4 || phase !== 2'd1) begin errors++;
      $display("FAIL close_before: got count %0d phase %0d expected 4 1", count, phase); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, MODE_VOTE, 6'd50, CAND_FIRE, 1'b1);
      checks++; if (count !== 4'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || phase !== 2'd2) begin errors++;
        $display("FAIL close_after: got count %0d valid %0b ready %0b phase %0d expected 0 0 0 2",
                 count, bus.out_valid, bus.in_ready, phase); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    idle(115);
    for (int i = 0; i < 5; i++) cycle(1'b1, MODE_VOTE, 6'(i + 1), CAND_AIR, 1'b0);
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL midreset_before: got %0d expected 5", count); end
    do_reset();
    checks++; if (count !== 4'd0 || phase !== 2'd0 || bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL midreset_after: got count %0d phase %0d valid %0b expected 0 0 0", count, phase, bus.out_valid); end
    idle(PHASE_LEN - 1);
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL midreset_timer99: got %0d expected 0", phase); end
    idle(1);
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL midreset_timer100: got %0d expected 1", phase); end
  endtask

  task automatic test_random();
    int exp_ph;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      exp_ph = exp_phase(m_timer);
      checks++; if (count !== 4'(m_q.size())) begin errors++;
        $display("FAIL rand_count@%0d: got %0d expected %0d", n, count, m_q.size()); end
      checks++; if (bus.out_valid !== (m_q.size() != 0)) begin errors++;
        $display("FAIL rand_valid@%0d: got %0b expected %0b", n, bus.out_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        checks++; if ({bus.out_mode, bus.out_user_id, bus.out_candidate} !== m_q[0]) begin errors++;
          $display("FAIL rand_head@%0d: got %0h expected %0h", n,
                   {bus.out_mode, bus.out_user_id, bus.out_candidate}, m_q[0]); end
      end else begin
        checks++; if ({bus.out_mode, bus.out_user_id, bus.out_candidate} !== 10'd0) begin errors++;
          $display("FAIL rand_head_gated@%0d: got %0h expected 0", n,
                   {bus.out_mode, bus.out_user_id, bus.out_candidate}); end
      end
      checks++; if (phase !== 2'(exp_ph)) begin errors++;
        $display("FAIL rand_phase@%0d: got %0d expected %0d", n, phase, exp_ph); end
      checks++; if (bus.in_ready !== ((m_q.size() < DEPTH) && exp_ph != 2)) begin errors++;
        $display("FAIL rand_ready@%0d: got %0b expected %0b", n, bus.in_ready, (m_q.size() < DEPTH) && exp_ph != 2); end
      checks++; if (drop_pulse !== m_drop) begin errors++;
        $display("FAIL rand_drop@%0d: got %0b expected %0b", n, drop_pulse, m_drop); end
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 9) < 7,
              ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3)),
              6'($urandom), 2'($urandom), $urandom_range(0, 9) < 4);
      end
    end
  endtask

  initial begin
    RST_N = 1'b0;
    bus.in_valid = 1'b0; bus.in_mode = 2'd0; bus.in_user_id = '0;
    bus.in_candidate = 2'd0; bus.out_ready = 1'b0;
    m_timer = 0; m_drop = 1'b0;
    @(negedge CLK);
    test_reset();
    test_order();
    test_full();
    test_illegal();
    test_phase_filter();
    test_close();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
